// File: rtl/fnn_wmem_pkg.sv
// Shared types and default sizing for the loadable FNN weight store.
package fnn_wmem_pkg;

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    LOADING   = 2'd1,
    LOADED    = 2'd2,
    STREAMING = 2'd3
  } wmem_state_e;

  localparam int NUM_WEIGHT_DEFAULT = 10;
  localparam int NUM_NEURON_DEFAULT = 4;
  localparam int DATA_WIDTH_DEFAULT = 16;

  // Counter width that stays at least one bit for a single-entry range.
  function automatic int ctr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/weight_bank_seq_w_mem_bank.sv
// One neuron's weight RAM: simple dual-port, synchronous write, registered read with enable.
module w_mem_bank #(
  parameter int depth        = 10,
  parameter int dataWidth    = 16,
  parameter int addressWidth = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [addressWidth-1:0] waddr,
  input  logic [dataWidth-1:0]    wdata,
  input  logic                    ren,
  input  logic [addressWidth-1:0] raddr,
  output logic [dataWidth-1:0]    rdata
);

  logic [dataWidth-1:0] mem_q [depth];
  logic [dataWidth-1:0] rdata_q;

  // Array contents are intentionally never reset; only the read register is.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // The read register holds its value while ren is low, which gives the output stall hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (ren) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/weight_bank_seq.sv
// Run-time loadable multi-neuron weight store with a backpressured read sequencer.
module weight_bank_seq
  import fnn_wmem_pkg::*;
#(
  parameter int numWeight    = NUM_WEIGHT_DEFAULT,
  parameter int numNeuron    = NUM_NEURON_DEFAULT,
  parameter int dataWidth    = DATA_WIDTH_DEFAULT,
  parameter int addressWidth = $clog2(numWeight),
  parameter int nrnWidth     = ctr_width(numNeuron)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              load_start,
  input  logic                              load_valid,
  input  logic [dataWidth-1:0]              load_data,
  output logic                              load_ready,
  input  logic                              rd_start,
  output logic [numNeuron*dataWidth-1:0]    wout,
  output logic                              wout_valid,
  output logic [addressWidth-1:0]           wout_idx,
  output logic                              wout_last,
  input  logic                              wout_ready,
  output logic                              loaded,
  output logic                              cmd_err
);

  localparam logic [addressWidth-1:0] LAST_IDX = addressWidth'(numWeight - 1);
  localparam logic [nrnWidth-1:0]     LAST_NRN = nrnWidth'(numNeuron - 1);

  wmem_state_e             state_q;
  logic [addressWidth-1:0] wr_idx_q;
  logic [nrnWidth-1:0]     wr_nrn_q;
  logic [addressWidth-1:0] rd_idx_q;
  logic                    fetch_done_q;
  logic                    load_ready_q;
  logic                    wout_valid_q;
  logic [addressWidth-1:0] wout_idx_q;
  logic                    wout_last_q;
  logic                    loaded_q;
  logic                    cmd_err_q;

  logic wr_en_d;
  logic rd_en_d;
  logic beat_done_d;

  // A word arriving together with load_start is dropped along with the partial load.
  assign wr_en_d     = (state_q == LOADING) && load_valid && !load_start;
  assign rd_en_d     = (state_q == STREAMING) && !fetch_done_q && (!wout_valid_q || wout_ready);
  assign beat_done_d = wout_valid_q && wout_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      wr_idx_q     <= '0;
      wr_nrn_q     <= '0;
      rd_idx_q     <= '0;
      fetch_done_q <= 1'b0;
      load_ready_q <= 1'b0;
      wout_valid_q <= 1'b0;
      wout_idx_q   <= '0;
      wout_last_q  <= 1'b0;
      loaded_q     <= 1'b0;
      cmd_err_q    <= 1'b0;
    end else begin
      cmd_err_q <= 1'b0;

      if (rd_en_d) begin
        wout_valid_q <= 1'b1;
        wout_idx_q   <= rd_idx_q;
        wout_last_q  <= (rd_idx_q == LAST_IDX);
        if (rd_idx_q == LAST_IDX) begin
          fetch_done_q <= 1'b1;
        end else begin
          rd_idx_q <= rd_idx_q + 1'b1;
        end
      end else if (beat_done_d) begin
        wout_valid_q <= 1'b0;
        wout_last_q  <= 1'b0;
      end

      case (state_q)
        EMPTY, LOADED: begin
          if (load_start) begin
            state_q      <= LOADING;
            wr_idx_q     <= '0;
            wr_nrn_q     <= '0;
            loaded_q     <= 1'b0;
            load_ready_q <= 1'b1;
            cmd_err_q    <= rd_start;
          end else if (rd_start) begin
            if (state_q == LOADED) begin
              state_q      <= STREAMING;
              rd_idx_q     <= '0;
              fetch_done_q <= 1'b0;
            end else begin
              cmd_err_q <= 1'b1;
            end
          end
        end

        LOADING: begin
          if (load_start) begin
            wr_idx_q  <= '0;
            wr_nrn_q  <= '0;
            cmd_err_q <= rd_start;
          end else begin
            cmd_err_q <= rd_start;
            if (wr_en_d) begin
              if (wr_idx_q == LAST_IDX) begin
                wr_idx_q <= '0;
                if (wr_nrn_q == LAST_NRN) begin
                  state_q      <= LOADED;
                  loaded_q     <= 1'b1;
                  load_ready_q <= 1'b0;
                end else begin
                  wr_nrn_q <= wr_nrn_q + 1'b1;
                end
              end else begin
                wr_idx_q <= wr_idx_q + 1'b1;
              end
            end
          end
        end

        STREAMING: begin
          cmd_err_q <= load_start || rd_start;
          if (beat_done_d && wout_last_q) begin
            state_q <= LOADED;
          end
        end

        default: state_q <= EMPTY;
      endcase
    end
  end

  for (genvar gi = 0; gi < numNeuron; gi++) begin : g_bank
    w_mem_bank #(
      .depth       (numWeight),
      .dataWidth   (dataWidth),
      .addressWidth(addressWidth)
    ) u_bank (
      .clk  (clk),
      .rst  (rst),
      .we   (wr_en_d && (wr_nrn_q == nrnWidth'(gi))),
      .waddr(wr_idx_q),
      .wdata(load_data),
      .ren  (rd_en_d),
      .raddr(rd_idx_q),
      .rdata(wout[gi*dataWidth +: dataWidth])
    );
  end

  assign load_ready = load_ready_q;
  assign wout_valid = wout_valid_q;
  assign wout_idx   = wout_idx_q;
  assign wout_last  = wout_last_q;
  assign loaded     = loaded_q;
  assign cmd_err    = cmd_err_q;

endmodule

// File: doc/weight_bank_seq.md
# weight_bank_seq

Loadable, multi-neuron weight store with an integrated read sequencer for the FNN accelerator. It replaces per-neuron hardcoded weight ROMs with RAM banks that are filled at run time over a valid/ready load stream. On command it streams every weight index to a layer's neuron MACs, one index per beat, with all neurons' weights in parallel. Output is backpressured with valid/ready and the final index is flagged, so the layer controller can sequence MAC accumulation and activation.

## Interface
- numWeight, 10: weights per neuron (layer fan-in), ≥2
- numNeuron, 4: neurons (banks) served in parallel, ≥1
- dataWidth, 16: weight word width (fixed-point, opaque here)
- addressWidth, $clog2(numWeight): bank address width
- nrnWidth, max(1,$clog2(numNeuron)): neuron counter width

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- load_start  in  1  pulse: begin full reload of all banks
- load_valid  in  1  load word present
- load_data  in  dataWidth  load word
- load_ready  out  1  load word accepted when valid&ready
- rd_start  in  1  pulse: stream one full pass
- wout  out  numNeuron*dataWidth  neuron n weight in bits [n*dataWidth +: dataWidth]
- wout_valid  out  1  wout holds index wout_idx
- wout_idx  out  addressWidth  weight index of current beat
- wout_last  out  1  beat is index numWeight-1
- wout_ready  in  1  consumer accepts beat
- loaded  out  1  all banks hold a complete weight set
- cmd_err  out  1  one-cycle pulse: command rejected

## Operation
- FSM states: EMPTY, LOADING, LOADED, STREAMING. Reset → EMPTY.
- EMPTY/LOADED + load_start → LOADING; wr_idx=0, wr_nrn=0, loaded=0.
- LOADING: load_ready=1. Each valid&ready writes load_data to bank wr_nrn, address wr_idx. Order is neuron-major: idx 0..numWeight-1 of neuron 0, then neuron 1, and so on.
- After the word at (numWeight-1, numNeuron-1): → LOADED, loaded=1. A partial load never sets loaded.
- load_start while LOADING restarts the counters (drops the partial load). load_start while STREAMING is ignored and pulses cmd_err.
- LOADED + rd_start → STREAMING, rd_idx=0.
- rd_start in EMPTY, LOADING or STREAMING is ignored and pulses cmd_err.
- load_start and rd_start together: load_start wins, and cmd_err pulses for the rd_start.
- STREAMING: a beat is accepted on wout_valid&wout_ready. rd_idx advances on each fetch and is not incremented past numWeight-1.
- After the last beat is accepted: → LOADED, and wout_valid drops next cycle unless a new fetch is pending. No wrap: each pass is exactly numWeight beats.
- Memory contents are not cleared by rst. Only loaded=0 gates their use.

## Timing
- Reset values: load_ready=0, wout=0, wout_valid=0, wout_idx=0, wout_last=0, loaded=0, cmd_err=0, state EMPTY, all counters 0.
- Bank read is synchronous (1 cycle). Read enable = STREAMING & fetch pending & (!wout_valid | wout_ready).
- rd_start accepted at cycle t → wout_valid=1 with idx 0 at t+2: the FSM registers at t+1 and the data registers at t+2.
- With wout_ready held high there is one beat per cycle. A pass of numWeight beats ends with wout_last on beat numWeight-1.
- wout_ready=0 while valid: wout, wout_idx, wout_last and wout_valid are held unchanged. No beat is lost or duplicated.
- Load is one word per cycle at full throughput. load_ready deasserts the cycle after the final word.
- loaded rises the cycle after the final load handshake.
- cmd_err is registered, so it pulses the cycle after the rejected command.
- rst mid-load or mid-stream: next cycle all outputs are at reset values, and any in-flight beat is discarded.

## Structure
- Package fnn_wmem_pkg holds the state enum (EMPTY, LOADING, LOADED, STREAMING) and shared default constants (numWeight, dataWidth).
- Sub-module w_mem_bank: one simple dual-port sync RAM (write port plus registered read with ren), instantiated numNeuron times with a generate loop.
- Top level holds the FSM, the wr_idx/wr_nrn/rd_idx counters, the output valid/idx/last registers and cmd_err.

## Test plan
- Load 40 words 0x0100+k (numWeight=10, numNeuron=4), then rd_start with ready=1 → 10 beats; beat i has neuron n = 0x0100+10n+i; last on i=9; loaded=1 after word 40.
- rd_start in EMPTY → cmd_err pulse 1 cycle later, no wout_valid.
- During streaming, drop wout_ready for 3 cycles at idx 4 → wout holds idx 4 values; sequence resumes with 5..9, no gaps or repeats.
- load_start after 17 words, then a full 40-word reload with new data → loaded rises only after the second reload; readback shows the new data only.
- load_start and rd_start in the same cycle while LOADED → enters LOADING, cmd_err pulses, no stream.
- Assert rst at beat 6 of a pass → all outputs 0 next cycle, state EMPTY.
